// File: rtl/iir_sched_pkg.sv
// Shared widths, default coefficients and FSM state type for the IIR channel scheduler.
package iir_sched_pkg;
  localparam int X_W     = 8;
  localparam int Y_W     = 13;
  localparam int SUM_W   = 26;
  localparam int XC_W    = 16;
  localparam int YC_W    = 12;
  localparam int ROUND_W = SUM_W + 2;

  localparam logic signed [XC_W-1:0] XC_DEFAULT = 16'h4CB3;
  localparam logic signed [YC_W-1:0] YC_DEFAULT = 12'h783;

  typedef enum logic [1:0] {ARB, MUL, SUM} sched_state_t;

  // Clamp an already-shifted rounded sum to the signed Y_W range.
  function automatic logic signed [Y_W-1:0] sat_y(input logic signed [ROUND_W-1:0] v);
    if (&v[ROUND_W-1:Y_W-1] || ~|v[ROUND_W-1:Y_W-1])
      return v[Y_W-1:0];
    return v[ROUND_W-1] ? {1'b1, {(Y_W-1){1'b0}}} : {1'b0, {(Y_W-1){1'b1}}};
  endfunction
endpackage

// File: rtl/iir_ch_scheduler_if.sv
// Sample-in / result-out bundle of the IIR channel scheduler.
interface iir_ch_scheduler_if import iir_sched_pkg::*; #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]     in_valid;
  logic [NUM_CH*X_W-1:0] in_data;
  logic [NUM_CH-1:0]     in_ready;
  logic                  clr;
  logic                  out_valid;
  logic [CH_W-1:0]       out_ch;
  logic [Y_W-1:0]        out_data;
  logic                  busy;

  modport master (output in_valid, in_data, clr,
                  input  in_ready, out_valid, out_ch, out_data, busy);
  modport slave  (input  in_valid, in_data, clr,
                  output in_ready, out_valid, out_ch, out_data, busy);
endinterface

// File: rtl/iir_rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr, with wrap.
module iir_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   idx
);
  logic            found;
  logic [CH_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(ptr) + i) % NUM_CH);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end
endmodule

// File: rtl/iir_ch_scheduler.sv
// One shared 1st-order IIR datapath serving NUM_CH channels in round-robin order.
// Define IIR_ROUND_EN for round-half-up with saturation instead of plain truncation.
module iir_ch_scheduler import iir_sched_pkg::*; #(
  parameter int                      NUM_CH = 4,
  parameter logic signed [XC_W-1:0]  XC     = XC_DEFAULT,
  parameter logic signed [YC_W-1:0]  YC     = YC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  iir_ch_scheduler_if.slave  bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int XM_W  = X_W + XC_W;
  localparam int YM_W  = Y_W + YC_W;
  localparam int SHIFT = SUM_W - Y_W;

  sched_state_t              state_reg;
  logic [CH_W-1:0]           rr_ptr_reg;
  logic [CH_W-1:0]           ch_reg;
  logic signed [X_W-1:0]     x_reg;
  logic signed [Y_W-1:0]     y_reg;
  logic signed [XM_W-1:0]    x_mul_reg;
  logic signed [YM_W-1:0]    y_mul_reg;
  logic                      out_valid_reg;
  logic [CH_W-1:0]           out_ch_reg;
  logic signed [Y_W-1:0]     out_data_reg;
  logic signed [Y_W-1:0]     y_state [NUM_CH];
  logic signed [Y_W-1:0]     y_next;
  logic signed [X_W-1:0]     x_in;
  logic [NUM_CH-1:0]         grant;
  logic [CH_W-1:0]           grant_idx;
  logic                      take;

  iir_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .req   (bus.in_valid),
    .ptr   (rr_ptr_reg),
    .grant (grant),
    .idx   (grant_idx)
  );

  // clr wins over a same-cycle transfer, so the grant is withheld while it is high.
  assign bus.in_ready = (state_reg == ARB && !bus.clr && !reset) ? grant : '0;
  assign take         = |bus.in_ready;
  assign x_in         = bus.in_data[int'(grant_idx)*X_W +: X_W];

`ifdef IIR_ROUND_EN
  logic signed [ROUND_W-1:0] sum_round;
  assign sum_round = (ROUND_W'(x_mul_reg) <<< 1) + (ROUND_W'(y_mul_reg) <<< 2)
                   + ROUND_W'(1 << (SHIFT - 1));
  assign y_next    = sat_y(sum_round >>> SHIFT);
`else
  // Wrap-around in SUM_W bits leaves the kept upper slice exact.
  logic signed [SUM_W-1:0] sum_trunc;
  assign sum_trunc = (SUM_W'(x_mul_reg) <<< 1) + (SUM_W'(y_mul_reg) <<< 2);
  assign y_next    = Y_W'(sum_trunc >>> SHIFT);
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ystate
    logic signed [Y_W-1:0] y_hold_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        y_hold_reg <= '0;
      else if (bus.clr)
        y_hold_reg <= '0;
      else if (state_reg == SUM && ch_reg == CH_W'(gi))
        y_hold_reg <= y_next;
    end
    assign y_state[gi] = y_hold_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ARB;
      rr_ptr_reg    <= CH_W'(NUM_CH - 1);
      ch_reg        <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      x_mul_reg     <= '0;
      y_mul_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= 1'b0;
      if (bus.clr) begin
        state_reg <= ARB;
      end else begin
        case (state_reg)
          ARB: if (take) begin
            x_reg      <= x_in;
            ch_reg     <= grant_idx;
            y_reg      <= y_state[grant_idx];
            rr_ptr_reg <= grant_idx;
            state_reg  <= MUL;
          end
          MUL: begin
            x_mul_reg <= XM_W'(x_reg) * XM_W'(XC);
            y_mul_reg <= YM_W'(y_reg) * YM_W'(YC);
            state_reg <= SUM;
          end
          SUM: begin
            out_data_reg  <= y_next;
            out_ch_reg    <= ch_reg;
            out_valid_reg <= 1'b1;
            state_reg     <= ARB;
          end
          default: state_reg <= ARB;
        endcase
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_ch    = out_ch_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.busy      = (state_reg == MUL) || (state_reg == SUM);
endmodule
